bridge_wb32_wb8: RTL and testbench

Width-converting Wishbone bridge between the 32-bit CPU bus and the 8-bit peripheral bus (LED register, UART, timer). It accepts one 32-bit request with byte selects and issues one 8-bit cycle per selected byte lane, lane 0 first. It assembles read bytes into a 32-bit word, then returns a single-cycle acknowledge. It also guards against unresponsive 8-bit slaves with a timeout.

---
 rtl/bridge_wb32_wb8.sv | 155 +++++++++++++++
 tb/tb_bridge_wb32_wb8.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_wb32_wb8.sv
// 32-bit to 8-bit Wishbone bridge: one 8-bit cycle per selected lane,
// read bytes assembled into a word, with an optional per-lane timeout.
module bridge_wb32_wb8 #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  I_wb_clk,
  input  logic                  I_reset,
  input  logic                  I_wb_stb,
  input  logic                  I_wb_we,
  input  logic [ADDR_WIDTH-1:0] I_wb_adr,
  input  logic [3:0]            I_wb_sel,
  input  logic [31:0]           I_wb_dat,
  output logic                  O_wb_ack,
  output logic                  O_wb_err,
  output logic [31:0]           O_wb_dat,
  output logic                  O_wb8_stb,
  output logic                  O_wb8_we,
  output logic [ADDR_WIDTH-1:0] O_wb8_adr,
  output logic [7:0]            O_wb8_dat,
  input  logic                  I_wb8_ack,
  input  logic [7:0]            I_wb8_dat
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:2] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           dat_q, dat_d;
  logic [31:0]           rd_q, rd_d;
  logic                  err_q, err_d;
  logic [1:0]            lane_q, lane_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  tmo;
  logic                  lane_ok;
  logic                  more;
  logic [7:0]            rbyte;
  logic                  unused_adr;

  assign unused_adr = ^I_wb_adr[1:0];

  function automatic logic [1:0] first_lane(input logic [3:0] s);
    first_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (s[i]) first_lane = 2'(i);
    end
  endfunction

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rd_d    = rd_q;
    err_d   = err_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    tmo     = 1'b0;
    lane_ok = 1'b0;
    rbyte   = 8'h00;
    more    = |(sel_q & (4'b1110 << lane_q));
    unique case (state_q)
      IDLE: begin
        if (I_wb_stb) begin
          adr_d   = I_wb_adr[ADDR_WIDTH-1:2];
          we_d    = I_wb_we;
          sel_d   = I_wb_sel;
          dat_d   = I_wb_dat;
          rd_d    = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          lane_d  = first_lane(I_wb_sel);
          state_d = (I_wb_sel == 4'b0000) ? DONE : REQ;
        end
      end
      REQ: begin
        cnt_d   = cnt_q + 8'd1;
        tmo     = (TIMEOUT != 0) && !I_wb8_ack &&
                  ({1'b0, cnt_q} + 9'd1 == 9'(TIMEOUT));
        lane_ok = I_wb8_ack || tmo;
        rbyte   = tmo ? 8'hFF : I_wb8_dat;
        if (lane_ok) begin
          if (!we_q) rd_d[{lane_q, 3'b000} +: 8] = rbyte;
          err_d   = err_q | tmo;
          state_d = more ? GAP : DONE;
        end
      end
      GAP: begin
        // acks seen here are leftovers from the previous lane
        lane_d  = first_lane(sel_q & (4'b1110 << lane_q));
        cnt_d   = '0;
        state_d = REQ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      lane_q    <= '0;
      cnt_q     <= '0;
      O_wb_ack  <= 1'b0;
      O_wb_err  <= 1'b0;
      O_wb_dat  <= '0;
      O_wb8_stb <= 1'b0;
      O_wb8_we  <= 1'b0;
      O_wb8_adr <= '0;
      O_wb8_dat <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      O_wb_ack  <= (state_d == DONE);
      O_wb8_stb <= (state_d == REQ);
      if (state_d == DONE) begin
        O_wb_dat <= rd_d;
        O_wb_err <= err_d;
      end else begin
        O_wb_err <= 1'b0;
      end
      if (state_d == REQ && state_q != REQ) begin
        O_wb8_adr <= {adr_d, lane_d};
        O_wb8_we  <= we_d;
        O_wb8_dat <= dat_d[{lane_d, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bridge_wb32_wb8.sv
// Bench for bridge_wb32_wb8: directed cases plus random transactions
// checked against a lane-list reference model and a byte memory.
module tb_bridge_wb32_wb8;

  localparam int AW  = 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stb = 1'b0;
  logic          we  = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [3:0]    sel = '0;
  logic [31:0]   wdat = '0;
  logic          ack;
  logic          err;
  logic [31:0]   rdat_o;
  logic          stb8;
  logic          we8;
  logic [AW-1:0] adr8;
  logic [7:0]    dat8_o;
  logic          ack8 = 1'b0;
  logic [7:0]    dat8_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bridge_wb32_wb8 #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .I_wb_clk (clk),
    .I_reset  (rst),
    .I_wb_stb (stb),
    .I_wb_we  (we),
    .I_wb_adr (adr),
    .I_wb_sel (sel),
    .I_wb_dat (wdat),
    .O_wb_ack (ack),
    .O_wb_err (err),
    .O_wb_dat (rdat_o),
    .O_wb8_stb(stb8),
    .O_wb8_we (we8),
    .O_wb8_adr(adr8),
    .O_wb8_dat(dat8_o),
    .I_wb8_ack(ack8),
    .I_wb8_dat(dat8_i)
  );

  // 8-bit slave: default contents, write overrides, request log
  logic [7:0] wmem [256];
  bit         wvalid [256];
  bit         noack_en  = 1'b0;
  bit         hold_mode = 1'b0;
  logic [7:0] noack_adr = 8'h00;
  int         hold = 0;
  int         run_len = 0;
  logic       stb_prev = 1'b0;
  logic [7:0] q_adr [$];
  logic [7:0] q_dat [$];
  logic       q_we  [$];
  int         q_len [$];
  logic [7:0] ref_mem [256];

  function automatic logic [7:0] dflt(input logic [7:0] a);
    case (a)
      8'h20:   return 8'h5A;
      8'h22:   return 8'h3C;
      8'h40:   return 8'h11;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  assign dat8_i = wvalid[adr8] ? wmem[adr8] : dflt(adr8);

  always @(posedge clk) begin
    stb_prev <= stb8;
    if (stb8) begin
      run_len <= stb_prev ? run_len + 1 : 1;
      if (!stb_prev) begin
        q_adr.push_back(adr8);
        q_dat.push_back(dat8_o);
        q_we.push_back(we8);
        if (we8) begin
          wmem[adr8]   <= dat8_o;
          wvalid[adr8] <= 1'b1;
        end
      end
    end else if (stb_prev) begin
      q_len.push_back(run_len);
    end
    if (stb8) begin
      ack8 <= !(noack_en && adr8 == noack_adr);
      hold <= hold_mode ? 2 : 0;
    end else if (hold > 0) begin
      ack8 <= 1'b1;
      hold <= hold - 1;
    end else begin
      ack8 <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_adr.delete();
    q_dat.delete();
    q_we.delete();
    q_len.delete();
  endtask

  task automatic run_txn(input logic [7:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] d,
                         output logic [31:0] rd, output logic e,
                         output int lat, output bit acked);
    clear_log();
    adr   = a;
    we    = w;
    sel   = s;
    wdat  = d;
    stb   = 1'b1;
    acked = 1'b0;
    lat   = 0;
    rd    = '0;
    e     = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 200; i++) begin
      #1;
      if (ack) begin
        lat   = i;
        acked = 1'b1;
        rd    = rdat_o;
        e     = err;
        break;
      end
      @(posedge clk);
    end
    stb = 1'b0;
    @(posedge clk);
    #1;
    chk("single_ack", ack, 1'b0);
  endtask

  // lanes expected = selected lanes in ascending order
  task automatic check_txn(input string tag, input logic [7:0] a,
                           input logic w, input logic [3:0] s,
                           input logic [31:0] d, input logic [31:0] rd,
                           input logic e, input int lat, input bit acked,
                           input bit timing);
    int         lanes [$];
    logic [31:0] exp_rd;
    logic [7:0]  la;
    exp_rd = '0;
    for (int i = 0; i < 4; i++) if (s[i]) lanes.push_back(i);
    chk({tag, "_acked"}, acked, 1'b1);
    chk({tag, "_err"}, e, 1'b0);
    if (timing)
      chk({tag, "_lat"}, lat, (lanes.size() == 0) ? 1 : 3 * lanes.size());
    chk({tag, "_nreq"}, q_adr.size(), lanes.size());
    foreach (lanes[k]) begin
      la = {a[7:2], 2'(lanes[k])};
      if (k < q_adr.size()) begin
        chk({tag, "_adr8"}, q_adr[k], la);
        chk({tag, "_we8"}, q_we[k], w);
        if (w) chk({tag, "_dat8"}, q_dat[k], d[8*lanes[k] +: 8]);
        if (timing && k < q_len.size()) chk({tag, "_len"}, q_len[k], 2);
      end
      if (w) ref_mem[la] = d[8*lanes[k] +: 8];
      else   exp_rd[8*lanes[k] +: 8] = ref_mem[la];
    end
    if (!w) chk({tag, "_rdat"}, rd, exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    bit          acked;
    bit          found;
    logic [7:0]  ra;
    logic        rw;
    logic [3:0]  rs;
    logic [31:0] rdw;

    for (int i = 0; i < 256; i++) ref_mem[i] = dflt(8'(i));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_dat", rdat_o, 32'h0);
    chk("rst_stb8", stb8, 1'b0);
    chk("rst_we8", we8, 1'b0);
    chk("rst_adr8", adr8, 8'h00);
    chk("rst_dat8", dat8_o, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    run_txn(8'h10, 1'b1, 4'b1111, 32'hA1B2C3D4, rd, e, lat, acked);
    check_txn("fullwr", 8'h10, 1'b1, 4'b1111, 32'hA1B2C3D4,
              rd, e, lat, acked, 1'b1);
    chk("fullwr_lat12", lat, 12);
    if (q_adr.size() == 4) begin
      chk("fullwr_a0", {q_adr[0], q_dat[0]}, 16'h10D4);
      chk("fullwr_a3", {q_adr[3], q_dat[3]}, 16'h13A1);
    end

    run_txn(8'h20, 1'b0, 4'b0101, 32'h0, rd, e, lat, acked);
    check_txn("sparse", 8'h20, 1'b0, 4'b0101, 32'h0,
              rd, e, lat, acked, 1'b1);
    chk("sparse_word", rd, 32'h003C005A);
    chk("sparse_lat", lat, 6);

    run_txn(8'h30, 1'b0, 4'b0000, 32'h0, rd, e, lat, acked);
    check_txn("empty", 8'h30, 1'b0, 4'b0000, 32'h0,
              rd, e, lat, acked, 1'b1);
    chk("empty_word", rd, 32'h0);

    noack_en  = 1'b1;
    noack_adr = 8'h41;
    run_txn(8'h40, 1'b0, 4'b0011, 32'h0, rd, e, lat, acked);
    noack_en  = 1'b0;
    chk("tmo_acked", acked, 1'b1);
    chk("tmo_word", rd, 32'h0000FF11);
    chk("tmo_err", e, 1'b1);
    chk("tmo_lat", lat, 3 + TMO + 1);
    chk("tmo_nreq", q_adr.size(), 2);
    if (q_len.size() == 2) begin
      chk("tmo_len0", q_len[0], 2);
      chk("tmo_len1", q_len[1], TMO);
    end

    hold_mode = 1'b1;
    run_txn(8'h50, 1'b1, 4'b1111, 32'h0BADF00D, rd, e, lat, acked);
    hold_mode = 1'b0;
    check_txn("stale", 8'h50, 1'b1, 4'b1111, 32'h0BADF00D,
              rd, e, lat, acked, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      ra  = 8'($urandom);
      rw  = 1'($urandom);
      rs  = 4'($urandom);
      rdw = $urandom;
      run_txn(ra, rw, rs, rdw, rd, e, lat, acked);
      check_txn("rand", ra, rw, rs, rdw, rd, e, lat, acked, 1'b1);
    end

    clear_log();
    adr   = 8'h80;
    we    = 1'b1;
    sel   = 4'b1111;
    wdat  = 32'h55667788;
    stb   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (stb8 && adr8[1:0] == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstmid_lane2", found, 1'b1);
    #2;
    rst = 1'b1;
    stb = 1'b0;
    #1;
    chk("rstmid_stb8", stb8, 1'b0);
    chk("rstmid_ack", ack, 1'b0);
    chk("rstmid_outs", {err, rdat_o, we8, adr8, dat8_o}, 50'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_txn(8'h90, 1'b0, 4'b0001, 32'h0, rd, e, lat, acked);
    check_txn("postrst", 8'h90, 1'b0, 4'b0001, 32'h0,
              rd, e, lat, acked, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
